// File: rtl/lrf_pkg.sv
// Shared definitions for the LRF synthetic frame source.
// Holds pattern encodings, FSM states, LFSR constants and a counter-width helper.
// No ports; imported by lrf_pix_counter and lrf_frame_source.
package lrf_pkg;

   localparam logic [1:0] PAT_RAMP   = 2'd0;   // x + y + f
   localparam logic [1:0] PAT_FRAME  = 2'd1;   // frame index
   localparam logic [1:0] PAT_XCOORD = 2'd2;   // column index
   localparam logic [1:0] PAT_NOISE  = 2'd3;   // LFSR bits, or zero when noise is compiled out

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      GAP    = 2'd2,
      DONE   = 2'd3
   } state_t;

   // Fibonacci LFSR, taps 16,14,13,11, shifting right.
   // Tap positions map to register bits 0,2,3,5.
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {^(s & LFSR_TAPS), s[15:1]};
   endfunction

   // Counter width for a range 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/lrf_pix_counter.sv
// Nested x/y/f wrap counter naming the next pixel the source will present.
// Latency: coordinates and flags are combinational from the state (or zero during clr_i); the state updates one cycle after adv_i.
// Backpressure: none internally; the owner asserts adv_i only when a beat is loaded.
// Ports: clk/aresetn (sync active-low), clr_i, adv_i, x_o/y_o/f_o, sof_o, eof_o, last_frame_o.
module lrf_pix_counter
   import lrf_pkg::*;
#(
   parameter int FRAME_WIDTH  = 512,
   parameter int FRAME_HEIGHT = 512,
   parameter int NUM_FRAMES   = 32,
   parameter int XW = cnt_w(FRAME_WIDTH),
   parameter int YW = cnt_w(FRAME_HEIGHT),
   parameter int FW = cnt_w(NUM_FRAMES)
) (
   input  logic          clk,
   input  logic          aresetn,
   input  logic          clr_i,
   input  logic          adv_i,
   output logic [XW-1:0] x_o,
   output logic [YW-1:0] y_o,
   output logic [FW-1:0] f_o,
   output logic          sof_o,
   output logic          eof_o,
   output logic          last_frame_o
);

   logic [XW-1:0] x_q, x_d, x_b;
   logic [YW-1:0] y_q, y_d, y_b;
   logic [FW-1:0] f_q, f_d, f_b;
   logic          x_end, y_end, f_end;

   // clr_i zeroes the visible coordinates in the same cycle, so a start can
   // load pixel (0,0,0) and step past it with a single adv_i.
   always_comb begin
      x_b   = clr_i ? '0 : x_q;
      y_b   = clr_i ? '0 : y_q;
      f_b   = clr_i ? '0 : f_q;
      x_end = (x_b == XW'(FRAME_WIDTH - 1));
      y_end = (y_b == YW'(FRAME_HEIGHT - 1));
      f_end = (f_b == FW'(NUM_FRAMES - 1));
      x_d   = x_b;
      y_d   = y_b;
      f_d   = f_b;
      if (adv_i) begin
         if (x_end) begin
            x_d = '0;
            if (y_end) begin
               y_d = '0;
               f_d = f_end ? '0 : f_b + FW'(1);
            end else begin
               y_d = y_b + YW'(1);
            end
         end else begin
            x_d = x_b + XW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!aresetn) begin
         x_q <= '0;
         y_q <= '0;
         f_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
         f_q <= f_d;
      end
   end

   assign x_o          = x_b;
   assign y_o          = y_b;
   assign f_o          = f_b;
   assign sof_o        = (x_b == '0) && (y_b == '0);
   assign eof_o        = x_end && y_end;
   assign last_frame_o = f_end;

endmodule

// File: rtl/lrf_frame_source.sv
// AXI4-Stream master emitting NUM_FRAMES synthetic FRAME_WIDTH x FRAME_HEIGHT frames per start.
// Latency: first beat valid one cycle after an accepted start; one beat per cycle while tready is high.
// Backpressure: holds tdata/tlast/tuser/tvalid stable while tvalid && !tready.
// Ports: aclk, aresetn (sync active-low), start, pattern_sel, busy, done, m_axis_* (tdata/tvalid/tready/tlast/tuser).
// Build option: define LRF_SRC_NOISE_EN to add the 16-bit LFSR for pattern 3 and bit-0 dither on patterns 0-2.
module lrf_frame_source
   import lrf_pkg::*;
#(
   parameter int FRAME_WIDTH  = 512,
   parameter int FRAME_HEIGHT = 512,
   parameter int PIXEL_WIDTH  = 8,
   parameter int NUM_FRAMES   = 32,
   parameter int FRAME_GAP    = 4
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic                   start,
   input  logic [1:0]             pattern_sel,
   output logic                   busy,
   output logic                   done,
   output logic [PIXEL_WIDTH-1:0] m_axis_tdata,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic                   m_axis_tlast,
   output logic                   m_axis_tuser
);

   localparam int  XW      = cnt_w(FRAME_WIDTH);
   localparam int  YW      = cnt_w(FRAME_HEIGHT);
   localparam int  FW      = cnt_w(NUM_FRAMES);
   localparam int  GW      = cnt_w(FRAME_GAP);
   localparam bit  HAS_GAP = (FRAME_GAP > 0);

   state_t                 state_q;
   logic [1:0]             pat_q;
   logic                   busy_q, done_q, tvalid_q, tlast_q, tuser_q, final_q;
   logic [PIXEL_WIDTH-1:0] tdata_q;
   logic [GW-1:0]          gap_q;

   logic          accept, start_ok, gap_end, load;
   logic [1:0]    pat_c;
   logic [XW-1:0] cx;
   logic [YW-1:0] cy;
   logic [FW-1:0] cf;
   logic          c_sof, c_eof, c_last_frame;
   logic [PIXEL_WIDTH-1:0] pix_c;

   assign accept   = tvalid_q && m_axis_tready;
   assign start_ok = (state_q == IDLE) && start;
   assign gap_end  = (state_q == GAP) && ((32'(gap_q) + 32'd1) >= FRAME_GAP);

   // The output registers are loaded with the pixel the counter points at:
   // on start, after a non-final beat is taken, or when a gap runs out.
   // A tlast beat that ends the burst or leads into a gap loads nothing.
   assign load = start_ok || gap_end ||
                 ((state_q == STREAM) && accept && !(tlast_q && (final_q || HAS_GAP)));

   // pattern_sel only matters in the start cycle; afterwards the latched copy rules.
   assign pat_c = start_ok ? pattern_sel : pat_q;

   lrf_pix_counter #(
      .FRAME_WIDTH  (FRAME_WIDTH),
      .FRAME_HEIGHT (FRAME_HEIGHT),
      .NUM_FRAMES   (NUM_FRAMES),
      .XW           (XW),
      .YW           (YW),
      .FW           (FW)
   ) u_cnt (
      .clk          (aclk),
      .aresetn      (aresetn),
      .clr_i        (start_ok),
      .adv_i        (load),
      .x_o          (cx),
      .y_o          (cy),
      .f_o          (cf),
      .sof_o        (c_sof),
      .eof_o        (c_eof),
      .last_frame_o (c_last_frame)
   );

`ifdef LRF_SRC_NOISE_EN
   // lfsr_q tracks the value belonging to the pixel the counter points at,
   // so it steps on every load; the visible beats still see one step per accepted beat.
   logic [15:0] lfsr_q, lfsr_c;
   assign lfsr_c = start_ok ? LFSR_SEED : lfsr_q;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         lfsr_q <= LFSR_SEED;
      end else if (load) begin
         lfsr_q <= lfsr_step(lfsr_c);
      end
   end
`endif

   always_comb begin
      case (pat_c)
         PAT_RAMP:   pix_c = PIXEL_WIDTH'(32'(cx) + 32'(cy) + 32'(cf));
         PAT_FRAME:  pix_c = PIXEL_WIDTH'(cf);
         PAT_XCOORD: pix_c = PIXEL_WIDTH'(cx);
`ifdef LRF_SRC_NOISE_EN
         default:    pix_c = PIXEL_WIDTH'(lfsr_c);
`else
         default:    pix_c = '0;
`endif
      endcase
`ifdef LRF_SRC_NOISE_EN
      if (pat_c != PAT_NOISE) begin
         pix_c[0] = pix_c[0] ^ lfsr_c[0];
      end
`endif
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q  <= IDLE;
         pat_q    <= PAT_RAMP;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         tuser_q  <= 1'b0;
         final_q  <= 1'b0;
         gap_q    <= '0;
      end else begin
         done_q <= 1'b0;
         if (load) begin
            tdata_q  <= pix_c;
            tuser_q  <= c_sof;
            tlast_q  <= c_eof;
            final_q  <= c_eof && c_last_frame;
            tvalid_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (start) begin
                  pat_q   <= pattern_sel;
                  busy_q  <= 1'b1;
                  state_q <= STREAM;
               end
            end
            STREAM: begin
               if (accept && tlast_q) begin
                  if (final_q) begin
                     state_q  <= DONE;
                     tvalid_q <= 1'b0;
                     busy_q   <= 1'b0;
                     done_q   <= 1'b1;
                  end else if (HAS_GAP) begin
                     state_q  <= GAP;
                     gap_q    <= '0;
                     tvalid_q <= 1'b0;
                  end
               end
            end
            GAP: begin
               if (gap_end) begin
                  state_q <= STREAM;
               end else begin
                  gap_q <= gap_q + GW'(1);
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign m_axis_tdata  = tdata_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;
   assign m_axis_tuser  = tuser_q;

endmodule

// File: tb/tb_lrf_frame_source.sv
// Directed bench for lrf_frame_source with a 4x2x3 geometry, one instance without and one with frame gaps.
// Latency: expects first beat one cycle after start, done one cycle after the final accepted beat.
// Backpressure: drives tready constant or random and checks stall stability.
module tb_lrf_frame_source;

   localparam int W     = 4;
   localparam int H     = 2;
   localparam int N     = 3;
   localparam int PW    = 8;
   localparam int BEATS = W * H * N;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          aresetn, start_a, start_b, tready;
   logic [1:0]    pat_sel;
   logic          busy_a, done_a, tvalid_a, tlast_a, tuser_a;
   logic          busy_b, done_b, tvalid_b, tlast_b, tuser_b;
   logic [PW-1:0] tdata_a, tdata_b;

   lrf_frame_source #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .PIXEL_WIDTH(PW),
                      .NUM_FRAMES(N), .FRAME_GAP(0)) u_dut (
      .aclk(clk), .aresetn(aresetn), .start(start_a), .pattern_sel(pat_sel),
      .busy(busy_a), .done(done_a), .m_axis_tdata(tdata_a), .m_axis_tvalid(tvalid_a),
      .m_axis_tready(tready), .m_axis_tlast(tlast_a), .m_axis_tuser(tuser_a));

   lrf_frame_source #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .PIXEL_WIDTH(PW),
                      .NUM_FRAMES(N), .FRAME_GAP(4)) u_dut_gap (
      .aclk(clk), .aresetn(aresetn), .start(start_b), .pattern_sel(pat_sel),
      .busy(busy_b), .done(done_b), .m_axis_tdata(tdata_b), .m_axis_tvalid(tvalid_b),
      .m_axis_tready(tready), .m_axis_tlast(tlast_b), .m_axis_tuser(tuser_b));

   int n_cmp = 0;
   int n_bad = 0;

   logic [PW-1:0] dq[$];
   logic          uq[$];
   logic          lq[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_nx(input logic [15:0] s);
      return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
   endfunction

   function automatic logic [PW-1:0] exp_pix(input logic [1:0] p, input int x, input int y,
                                             input int f, input logic [15:0] l);
      logic [PW-1:0] v;
      case (p)
         2'd0:    v = PW'(x + y + f);
         2'd1:    v = PW'(f);
         2'd2:    v = PW'(x);
`ifdef LRF_SRC_NOISE_EN
         default: v = l[PW-1:0];
`else
         default: v = '0;
`endif
      endcase
`ifdef LRF_SRC_NOISE_EN
      if (p != 2'd3) v[0] = v[0] ^ l[0];
`endif
      return v;
   endfunction

   // Runs one burst on the gapless instance and checks every accepted beat.
   task automatic burst_a(input logic [1:0] pat, input bit rnd, input bit poke, input string tag);
      int            cyc    = 0;
      int            busy_n = 0;
      bit            got_done = 0;
      logic          pv = 0, pr = 0, pu = 0, pl = 0;
      logic [PW-1:0] pd = '0;
      logic [15:0]   l;
      int            k;
      dq.delete(); uq.delete(); lq.delete();
      @(posedge clk); #1 pat_sel = pat; start_a = 1'b1; tready = 1'b1;
      @(posedge clk); #1 start_a = 1'b0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         cyc++;
         if (c == 0) begin
            check({tag, "_first_vld"}, tvalid_a, 1);
            check({tag, "_first_busy"}, busy_a, 1);
         end
         if (pv && !pr) begin
            check({tag, "_stall_vld"}, tvalid_a, 1);
            check({tag, "_stall_dat"}, tdata_a, pd);
            check({tag, "_stall_usr"}, tuser_a, pu);
            check({tag, "_stall_lst"}, tlast_a, pl);
         end
         if (tvalid_a && tready) begin
            dq.push_back(tdata_a); uq.push_back(tuser_a); lq.push_back(tlast_a);
         end
         if (busy_a) busy_n++;
         if (done_a) begin
            got_done = 1;
            check({tag, "_busy_at_done"}, busy_a, 0);
            check({tag, "_vld_at_done"}, tvalid_a, 0);
            break;
         end
         pv = tvalid_a; pr = tready; pd = tdata_a; pu = tuser_a; pl = tlast_a;
         @(posedge clk); #1
         tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (poke) begin
            start_a = ~start_a;
            pat_sel = 2'($urandom_range(0, 3));
         end
      end
      start_a = 1'b0;
      pat_sel = pat;
      check({tag, "_done_seen"}, got_done, 1);
      check({tag, "_beats"}, dq.size(), BEATS);
      if (!rnd) begin
         check({tag, "_busy_cycles"}, busy_n, BEATS);
         check({tag, "_cycles"}, cyc, BEATS + 1);
      end
      l = 16'hACE1;
      k = 0;
      for (int f = 0; f < N; f++)
         for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
               if (k < dq.size()) begin
                  check({tag, "_dat"}, dq[k], exp_pix(pat, x, y, f, l));
                  check({tag, "_usr"}, uq[k], (x == 0 && y == 0));
                  check({tag, "_lst"}, lq[k], (x == W - 1 && y == H - 1));
               end
               l = lfsr_nx(l);
               k++;
            end
   endtask

   initial begin
      int          nb, gapn;
      bit          b_done;
      logic [15:0] l;
      aresetn = 1'b0; start_a = 1'b0; start_b = 1'b0; tready = 1'b0; pat_sel = 2'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy_a, 0);
      check("rst_done", done_a, 0);
      check("rst_tdata", tdata_a, 0);
      check("rst_tvalid", tvalid_a, 0);
      check("rst_tlast", tlast_a, 0);
      check("rst_tuser", tuser_a, 0);
      check("rst_b_tvalid", tvalid_b, 0);
      check("rst_b_busy", busy_b, 0);
      @(posedge clk); #1 aresetn = 1'b1;

      // Ramp, full throughput.
      burst_a(2'd0, 0, 0, "ramp");
`ifndef LRF_SRC_NOISE_EN
      if (dq.size() == BEATS) begin
         check("ramp_beat1_dat", dq[0], 0);
         check("ramp_beat8_dat", dq[7], 4);
         check("ramp_beat8_lst", lq[7], 1);
         check("ramp_beat9_dat", dq[8], 1);
         check("ramp_beat9_usr", uq[8], 1);
         check("ramp_beat24_dat", dq[23], 6);
      end
`endif

      // Random backpressure, x-coordinate pattern.
      burst_a(2'd2, 1, 0, "rdy");
      // Start pulsed and pattern_sel churned mid-burst.
      burst_a(2'd2, 0, 1, "poke");
      // Started exactly one cycle after the previous done.
      burst_a(2'd1, 0, 0, "again");

      // Reset during frame 1.
      @(posedge clk); #1 pat_sel = 2'd0; start_a = 1'b1; tready = 1'b1;
      @(posedge clk); #1 start_a = 1'b0;
      repeat (9) @(posedge clk);
      #1 aresetn = 1'b0;
      @(posedge clk); #1 aresetn = 1'b1;
      @(negedge clk);
      check("midrst_tvalid", tvalid_a, 0);
      check("midrst_busy", busy_a, 0);
      burst_a(2'd0, 0, 0, "post_rst");

      // Gapped instance, frame-index pattern.
      @(posedge clk); #1 pat_sel = 2'd1; start_b = 1'b1; tready = 1'b1;
      @(posedge clk); #1 start_b = 1'b0;
      nb = 0; gapn = 0; b_done = 0; l = 16'hACE1;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (done_b) begin
            b_done = 1;
            break;
         end
         if (tvalid_b) begin
            if (nb > 0 && tuser_b) check("gap_len", gapn, 4);
            if (nb > 0 && !tuser_b) check("gap_inframe_idle", gapn, 0);
            check("gap_dat", tdata_b, exp_pix(2'd1, nb % W, (nb / W) % H, nb / (W * H), l));
            check("gap_lst", tlast_b, (nb % (W * H)) == (W * H - 1));
            l = lfsr_nx(l);
            nb++;
            gapn = 0;
         end else begin
            gapn++;
         end
      end
      check("gap_done_seen", b_done, 1);
      check("gap_beats", nb, BEATS);

      // Noise pattern with backpressure.
      burst_a(2'd3, 1, 0, "noise");
`ifdef LRF_SRC_NOISE_EN
      if (dq.size() > 0) check("noise_first", dq[0], 8'hE1);
`else
      if (dq.size() > 0) check("noise_first", dq[0], 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lrf_frame_source.md
Name: lrf_frame_source

Overview:
AXI4-Stream master that produces a programmable burst of NUM_FRAMES synthetic frames. Each frame is FRAME_WIDTH x FRAME_HEIGHT pixels, with tlast on the last pixel of every frame. It is the upstream transmitter for the LRF frame-accumulation/readout block. It is used as the stimulus source on-chip and in system simulation. Output is fully registered, and the block honours backpressure.

Parameters:
FRAME_WIDTH, 512, pixels per line
FRAME_HEIGHT, 512, lines per frame
PIXEL_WIDTH, 8, bits per pixel
NUM_FRAMES, 32, frames emitted per start
FRAME_GAP, 4, idle cycles (tvalid low) between frames; 0 = back-to-back

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
start  in  1  one-cycle request to begin a burst; sampled only in IDLE
pattern_sel  in  2  pattern select, latched on accepted start
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the final beat is accepted
m_axis_tdata  out  PIXEL_WIDTH  pixel value
m_axis_tvalid  out  1  beat valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  last pixel of current frame
m_axis_tuser  out  1  first pixel of current frame (SOF)

Behaviour:
- Reset (aresetn=0 at a rising edge): state=IDLE; x, y and frame counters=0. All outputs are 0: busy, done, tdata, tvalid, tlast, tuser.
- Counters: x in 0..FRAME_WIDTH-1, y in 0..FRAME_HEIGHT-1, f in 0..NUM_FRAMES-1. Widths are $clog2 of each bound, minimum 1.
- Pixel value is computed modulo 2^PIXEL_WIDTH:
  - pattern 0: x+y+f
  - pattern 1: f
  - pattern 2: x
  - pattern 3: 0 (or noise, see Optional Feature)
- tuser=1 iff x=0 and y=0. tlast=1 iff x=FRAME_WIDTH-1 and y=FRAME_HEIGHT-1.
- States:
  - IDLE: when start=1, latch pattern_sel, clear counters, go to STREAM. On the next cycle, tvalid=1 with pixel (0,0,0), tuser=1, and busy=1. Start-to-first-valid latency is 1 cycle.
  - STREAM: a beat is accepted when tvalid&&tready.
    - While tvalid=1 && tready=0, tdata, tlast and tuser stay stable.
    - On accept, advance x; wrap x to 0 and advance y. One beat per cycle is sustained while tready=1.
    - On accepting the tlast beat with f<NUM_FRAMES-1: f++, x=y=0. Go to GAP if FRAME_GAP>0, otherwise present the next frame's SOF beat the next cycle.
    - On accepting the tlast beat with f=NUM_FRAMES-1: go to DONE; tvalid=0 next cycle.
  - GAP: tvalid=0 for exactly FRAME_GAP cycles, then STREAM presenting the SOF beat.
  - DONE: done=1 and busy=0 for one cycle, then IDLE. A new start may be accepted on the following cycle.
- start outside IDLE (or during the DONE cycle) is ignored. pattern_sel changes mid-burst have no effect.
- tvalid never drops without an accepted beat, except via reset.
- Reset mid-frame: next cycle tvalid=0 and busy=0. No tlast is emitted for the truncated frame.
- Degenerate size FRAME_WIDTH=FRAME_HEIGHT=1: every beat has both tuser and tlast.

Optional Feature:
Macro LRF_SRC_NOISE_EN.
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on accepted start and on reset) advances once per accepted beat. Pattern 3 outputs LFSR[PIXEL_WIDTH-1:0], and patterns 0-2 are XORed with LFSR[0] at bit 0 (±1 dither).
- Undefined: no LFSR logic exists, pattern 3 outputs 0, and patterns 0-2 are undithered.

Decomposition:
- Package lrf_pkg: pattern-select encodings (PAT_RAMP=0, PAT_FRAME=1, PAT_XCOORD=2, PAT_NOISE=3), state enum (IDLE, STREAM, GAP, DONE), LFSR seed and tap constants.
- One natural sub-module: lrf_pix_counter, the x/y/f nested wrap counter with an advance input and sof/eof/last_frame flags. The top holds the FSM, pattern mux and output registers.

Test Plan:
- W=4, H=2, N=3, GAP=0, pattern 0, tready=1: exactly 24 beats, one per cycle, first tdata=0. Beat 8 (f=0,x=3,y=1) has tdata=4 and tlast=1. Beat 9 has tdata=1 and tuser=1. done pulses one cycle after beat 24; busy is high for 24 cycles.
- Same sizes, GAP=4, pattern 1: tdata per frame is 0,1,2. Exactly 4 tvalid-low cycles between each tlast beat and the next SOF beat.
- Random tready (50%): the accepted-beat sequence equals the tready=1 sequence. tdata, tlast and tuser are stable across every stalled cycle; tvalid never drops while stalled.
- start pulsed repeatedly mid-burst and pattern_sel toggled: burst length is still W*H*N and the pattern stays unchanged. A second start one cycle after done begins a new burst at (0,0,0).
- aresetn low for 1 cycle mid-frame 1, then start: next cycle tvalid=0 and busy=0. The new burst restarts at tdata=0 with tuser=1.
- With LRF_SRC_NOISE_EN, pattern 3, PIXEL_WIDTH=8: first beat tdata=8'hE1. The sequence matches a reference LFSR advancing only on accepted beats. Without the macro, pattern 3 gives all-zero beats.
